// File: rtl/imem_fetch_buffer.sv
`default_nettype none
// ============================================================================
// Module   : imem_fetch_buffer
// Purpose  : Instruction-fetch bridge between the core instruction port and
//            a multi-cycle instruction memory. A direct-mapped fetch buffer
//            serves hits in the same cycle. A miss stalls the core and issues
//            one memory read. The returned word is written into the buffer
//            and passed straight to the core in the same cycle.
// Ports    : clk, rst (async, active-low)
//            cpu_ce_i / cpu_addr_i        - core fetch request
//            cpu_inst_o / cpu_stall_o     - instruction and hold-PC (combinational)
//            flush_i                      - invalidate every buffer entry
//            mem_ce_o / mem_addr_o        - memory read strobe and address (registered)
//            mem_data_i                   - memory read data
//            hit_cnt_o / miss_cnt_o       - saturating 16-bit hit and fill counters
// Revision : 1.0 - initial release
// ============================================================================
module imem_fetch_buffer #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int WAIT_STATES = 2,
  parameter int BUF_DEPTH   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_ce_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  output logic [DATA_W-1:0] cpu_inst_o,
  output logic              cpu_stall_o,
  input  logic              flush_i,
  output logic              mem_ce_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [DATA_W-1:0] mem_data_i,
  output logic [15:0]       hit_cnt_o,
  output logic [15:0]       miss_cnt_o
);

  localparam int IDX_W = $clog2(BUF_DEPTH);
  localparam int TAG_W = ADDR_W - IDX_W - 2;
  localparam int CNT_W = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
  localparam logic [CNT_W-1:0] C_CNT_LOAD = CNT_W'(WAIT_STATES - 1);
  localparam logic [15:0]      C_CNT_MAX  = 16'hFFFF;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [BUF_DEPTH-1:0]  r_valid;
  logic [TAG_W-1:0]      r_tag  [BUF_DEPTH];
  logic [DATA_W-1:0]     r_data [BUF_DEPTH];
  logic                  r_mem_ce;
  logic [ADDR_W-1:0]     r_mem_addr;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_stale;
  logic [15:0]           r_hit_cnt;
  logic [15:0]           r_miss_cnt;

  logic [IDX_W-1:0]      w_idx;
  logic [TAG_W-1:0]      w_tag;
  logic [IDX_W-1:0]      w_fill_idx;
  logic [TAG_W-1:0]      w_fill_tag;
  logic                  w_hit;
  logic                  w_miss_start;
  logic                  w_fill_we;
  logic                  w_hit_inc;
  logic                  w_unused_addr;

  assign w_idx      = cpu_addr_i[IDX_W+1:2];
  assign w_tag      = cpu_addr_i[ADDR_W-1:IDX_W+2];
  // The fill target comes from the latched request address, not the live one.
  assign w_fill_idx = r_mem_addr[IDX_W+1:2];
  assign w_fill_tag = r_mem_addr[ADDR_W-1:IDX_W+2];
  assign w_hit      = cpu_ce_i & r_valid[w_idx] & (r_tag[w_idx] == w_tag);

  // Byte offset within the word carries no information for a fetch.
  assign w_unused_addr = ^cpu_addr_i[1:0];

  assign mem_ce_o   = r_mem_ce;
  assign mem_addr_o = r_mem_addr;
  assign hit_cnt_o  = r_hit_cnt;
  assign miss_cnt_o = r_miss_cnt;

  // --------------------------------------------------------------------------
  // Next-state and core-facing outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_next       = r_state;
    cpu_inst_o   = '0;
    cpu_stall_o  = 1'b0;
    w_miss_start = 1'b0;
    w_fill_we    = 1'b0;
    w_hit_inc    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cpu_ce_i) begin
          if (w_hit) begin
            cpu_inst_o = r_data[w_idx];
            w_hit_inc  = 1'b1;
          end else begin
            cpu_stall_o  = 1'b1;
            w_miss_start = 1'b1;
            w_next       = S_REQ;
          end
        end
      end
      S_REQ: begin
        cpu_stall_o = 1'b1;
        w_next      = S_WAIT;
      end
      S_WAIT: begin
        if (r_cnt != '0) begin
          cpu_stall_o = 1'b1;
        end else begin
          w_next = S_IDLE;
          // A flush seen during the fill (or right now) makes the returned
          // word untrustworthy: drop it and let IDLE re-miss.
          if (r_stale || flush_i) begin
            cpu_stall_o = 1'b1;
          end else begin
            w_fill_we = 1'b1;
            if (cpu_ce_i) begin
              cpu_inst_o = mem_data_i;
            end
          end
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Control state
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_valid    <= '0;
      r_mem_ce   <= 1'b0;
      r_mem_addr <= '0;
      r_cnt      <= '0;
      r_stale    <= 1'b0;
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else begin
      r_state  <= w_next;
      // Strobe is high exactly for the REQ cycle.
      r_mem_ce <= w_miss_start;
      if (w_miss_start) begin
        r_mem_addr <= {cpu_addr_i[ADDR_W-1:2], 2'b00};
      end

      if (r_state == S_REQ) begin
        r_cnt <= C_CNT_LOAD;
      end else if ((r_state == S_WAIT) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - 1'b1;
      end

      if (w_next == S_IDLE) begin
        r_stale <= 1'b0;
      end else if (flush_i && (r_state != S_IDLE)) begin
        r_stale <= 1'b1;
      end

      if (flush_i) begin
        r_valid <= '0;
      end else if (w_fill_we) begin
        r_valid[w_fill_idx] <= 1'b1;
      end

      if (w_hit_inc && (r_hit_cnt != C_CNT_MAX)) begin
        r_hit_cnt <= r_hit_cnt + 16'd1;
      end
      if ((r_state == S_REQ) && (r_miss_cnt != C_CNT_MAX)) begin
        r_miss_cnt <= r_miss_cnt + 16'd1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Buffer storage: contents are qualified by r_valid, so no reset needed.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_fill_we) begin
      r_tag[w_fill_idx]  <= w_fill_tag;
      r_data[w_fill_idx] <= mem_data_i;
    end
  end

endmodule
`default_nettype wire

// File: doc/imem_fetch_buffer.md
# imem_fetch_buffer

Parametrised instruction-fetch bridge placed between the mips core's instruction port and a multi-cycle instruction memory in the next-generation SoC top. It replaces the direct, zero-latency core-to-ROM connection. It adds a direct-mapped fetch buffer, a configurable memory read latency, a stall output to the core, flush support and hit/miss counters. Hits return in the same cycle. Misses issue a single memory read and forward the returned word to the core as it is written into the buffer.

## Interface
Parameters:
- ADDR_W, 32, address width (byte address, word-aligned use)
- DATA_W, 32, instruction width
- WAIT_STATES, 2, memory read latency in cycles (≥1): data valid WAIT_STATES cycles after the mem_ce_o cycle
- BUF_DEPTH, 4, buffer entries (power of 2, ≥2); IDX_W = log2(BUF_DEPTH)

Ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- cpu_ce_i  in  1  core fetch enable
- cpu_addr_i  in  ADDR_W  core fetch address; bits [1:0] ignored
- cpu_inst_o  out  DATA_W  instruction to core
- cpu_stall_o  out  1  core must hold PC/address while high
- flush_i  in  1  invalidate all buffer entries (one-cycle pulse)
- mem_ce_o  out  1  memory read strobe, one cycle per fill
- mem_addr_o  out  ADDR_W  memory read address, [1:0]=0
- mem_data_i  in  DATA_W  memory read data
- hit_cnt_o  out  16  saturating hit count
- miss_cnt_o  out  16  saturating fill count

## Operation
- Address split: index = addr[IDX_W+1:2], tag = addr[ADDR_W-1:IDX_W+2]. Each entry holds valid, tag and data.
- hit = cpu_ce_i & valid[index] & tag match (combinational).
- FSM states IDLE, REQ, WAIT.
- IDLE, cpu_ce_i=0: cpu_inst_o=0, stall=0.
- IDLE, hit: cpu_inst_o=entry data, stall=0, hit_cnt_o+1.
- IDLE, miss: stall=1. Latch {addr[ADDR_W-1:2],2'b00} into mem_addr_o, then go to REQ.
- REQ: mem_ce_o=1, stall=1, miss_cnt_o+1. Load cnt=WAIT_STATES-1, then go to WAIT.
- WAIT, cnt≠0: stall=1, cnt−1.
- WAIT, cnt=0 (data cycle):
  - write mem_data_i, tag and valid=1 into the entry for mem_addr_o, then go to IDLE;
  - if cpu_ce_i=1, also bypass: cpu_inst_o=mem_data_i and stall=0;
  - if cpu_ce_i=0, the fill is still written, output is 0 and stall=0.
- Core contract: cpu_addr_i is held stable while stall=1; the bridge does not re-check it.
- flush_i, any state:
  - all valid bits clear at the next edge;
  - a fill in REQ/WAIT is marked stale;
  - a stale data cycle writes nothing, does not bypass, keeps stall=1 and returns to IDLE, where the request re-misses and a new fill issues.
- flush_i in the same cycle as a data cycle: the fill is discarded, as above.
- Counters saturate at 0xFFFF. They are cleared only by reset.

## Timing
- Reset values (rst=0, async): state IDLE, all valid=0, mem_ce_o=0, mem_addr_o=0, cnt=0, stale=0, hit_cnt_o=0, miss_cnt_o=0.
- Reset values, combinational outputs with cpu_ce_i=0: cpu_inst_o=0, cpu_stall_o=0.
- Reset mid-fill: the fill is aborted and late mem_data_i is ignored.
- Hit: zero latency, combinational from cpu_addr_i.
- Miss detected in cycle M:
  - mem_ce_o high in cycle M+1 only;
  - mem_data_i sampled in cycle M+1+WAIT_STATES;
  - stall high for WAIT_STATES+1 cycles (M..M+WAIT_STATES), low in the data cycle.
- Back-to-back: the next address presented after a bypass is evaluated in IDLE the following cycle.
- Only one outstanding fill exists at any time.
- mem_ce_o and mem_addr_o are registered. cpu_inst_o and cpu_stall_o are combinational.

## Test plan
- Reset, then cpu_ce_i=0: cpu_inst_o=0, stall=0, mem_ce_o=0, both counters 0.
- WAIT_STATES=2, cold fetch at 0x0000_0000 in cycle 0, memory returns 0x3401_0001 in cycle 3:
  - stall high in cycles 0-2, mem_ce_o high in cycle 1 only;
  - cycle 3 output 0x3401_0001 with stall=0;
  - miss_cnt_o=1.
- Refetch 0x0000_0000: same-cycle hit, stall=0, hit_cnt_o increments.
- Conflict: 0x0000_0000 then 0x0000_0010 (BUF_DEPTH=4, same index, different tag): second fetch misses, then 0x0 misses again; miss_cnt_o=3.
- flush_i in the WAIT cycle of a fill for 0x4: data cycle does not bypass and stall stays high; a new REQ follows; core receives the word WAIT_STATES+1 cycles after re-entering IDLE.
- Reset asserted mid-WAIT, then a fetch to the same address: miss reissued, counters restart from 0. Separately, force hit_cnt_o to 0xFFFF by 65535+ hits: it holds at 0xFFFF.
